// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared width default and FSM state type for the PISO serializer
package sr_pkg;

  localparam int SR_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sr_state_t;

endpackage

// File: rtl/piso_shreg.sv
// rtl/piso_shreg.sv - parallel-load, shift-left register exposing its MSB
module piso_shreg
  import sr_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sreg;

  // Zero fill on shift leaves the register clear once a word has drained,
  // so the MSB reads 0 whenever nothing is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/sr_piso_ctrl.sv
// rtl/sr_piso_ctrl.sv - handshake, FSM and bit counter driving an MSB-first serial stream
module sr_piso_ctrl
  import sr_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             word_done
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sr_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last_bit;
  logic          accept;
  logic          shift_en;
  logic          sout_valid_q, frame_start_q, word_done_q;

  // The counter tracks the bit currently on sout, so ready opens during the last bit.
  assign last_bit   = (state == SHIFT) && (cnt == LAST);
  assign load_ready = (state == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;
  assign shift_en   = (state == SHIFT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (accept) begin
          cnt_nxt = '0;
        end else if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      word_done_q   <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      sout_valid_q  <= (state_nxt == SHIFT);
      frame_start_q <= accept;
      word_done_q   <= (state_nxt == SHIFT) && (cnt_nxt == LAST);
    end
  end

  // Reset has priority inside the register, so a handshake during reset is dropped.
  piso_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk  (clk),
    .reset(reset),
    .load (accept),
    .shift(shift_en),
    .din  (din),
    .msb  (sout)
  );

  assign sout_valid  = sout_valid_q;
  assign frame_start = frame_start_q;
  assign word_done   = word_done_q;

endmodule

// File: tb/tb_sr_piso_ctrl.sv
// tb/tb_sr_piso_ctrl.sv - randomized and directed bench with a bit-queue reference model
module tb_sr_piso_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] din;
  logic         load_valid;
  logic         load_ready;
  logic         sout;
  logic         sout_valid;
  logic         frame_start;
  logic         word_done;

  logic         reset4;
  logic [3:0]   din4;
  logic         lv4;
  logic         ready4;
  logic         sout4;
  logic         sv4;
  logic         fs4;
  logic         wd4;

  int           checks = 0;
  int           errors = 0;
  bit           chk_en = 0;

  logic [2:0]   mq[$];
  logic [W-1:0] sipo_q = '0;
  logic [W-1:0] got;
  logic [15:0]  got16;
  logic [3:0]   got4;

  sr_piso_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .frame_start(frame_start),
    .word_done  (word_done)
  );

  sr_piso_ctrl #(.WIDTH(4)) dut4 (
    .clk        (clk),
    .reset      (reset4),
    .din        (din4),
    .load_valid (lv4),
    .load_ready (ready4),
    .sout       (sout4),
    .sout_valid (sv4),
    .frame_start(fs4),
    .word_done  (wd4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream SIPO fed by sout
  always @(posedge clk) sipo_q <= {sipo_q[W-2:0], sout};

  // Reference model: queue of {bit, first, last} still to appear on sout; head is on the wire now.
  always @(posedge clk) begin
    bit acc;
    if (reset) begin
      mq.delete();
    end else begin
      acc = load_valid && (mq.size() <= 1);
      if (mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        for (int i = W - 1; i >= 0; i--) mq.push_back({din[i], i == W - 1, i == 0});
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] f;
    if (chk_en) begin
      f = (mq.size() > 0) ? mq[0] : 3'b000;
      check("m_ready",       32'(load_ready),  32'(mq.size() <= 1));
      check("m_sout_valid",  32'(sout_valid),  32'(mq.size() > 0));
      check("m_sout",        32'(sout),        32'(f[2]));
      check("m_frame_start", 32'(frame_start), 32'(f[1]));
      check("m_word_done",   32'(word_done),   32'(f[0]));
    end
  end

  initial begin
    reset = 1'b1; reset4 = 1'b1; load_valid = 1'b0; din = '0;
    lv4 = 1'b0; din4 = '0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; reset4 = 1'b0;
    check("rst_sout",        32'(sout),        32'd0);
    check("rst_sout_valid",  32'(sout_valid),  32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_word_done",   32'(word_done),   32'd0);
    check("rst_ready",       32'(load_ready),  32'd1);

    // Single word A5, din scrambled once the word is in flight
    din = 8'hA5; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; din = W'($urandom);
    got = '0;
    for (int i = 0; i < W; i++) begin
      if (i > 0) @(negedge clk);
      got = {got[W-2:0], sout};
      if (i == 0) check("a5_frame_start", 32'(frame_start), 32'd1);
      if (i == W - 1) check("a5_word_done", 32'(word_done), 32'd1);
    end
    check("a5_bits", 32'(got), 32'hA5);
    @(negedge clk);
    check("a5_sipo", 32'(sipo_q), 32'hA5);
    check("a5_gap_valid", 32'(sout_valid), 32'd0);

    // Idle with random din and no load_valid
    for (int i = 0; i < 20; i++) begin
      din = W'($urandom);
      @(negedge clk);
      check("idle_ready", 32'(load_ready), 32'd1);
      check("idle_sout", 32'(sout), 32'd0);
      check("idle_valid", 32'(sout_valid), 32'd0);
    end

    // Back-to-back FF then 00
    din = 8'hFF; load_valid = 1'b1;
    got16 = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) din = 8'h00;
      if (i == 8) load_valid = 1'b0;
      got16 = {got16[14:0], sout};
      check("b2b_valid", 32'(sout_valid), 32'd1);
      check("b2b_ready", 32'(load_ready), 32'((i == 7) || (i == 15)));
    end
    check("b2b_bits", 32'(got16), 32'hFF00);
    @(negedge clk);
    check("b2b_end_valid", 32'(sout_valid), 32'd0);

    // Backpressure: 3C offered mid-word, din churned before it
    din = 8'h5A; load_valid = 1'b1;
    got16 = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      got16 = {got16[14:0], sout};
      check("bp_frame_start", 32'(frame_start), 32'((i == 0) || (i == 8)));
      if (i == 0) begin load_valid = 1'b0; din = W'($urandom); end
      if (i == 2) begin load_valid = 1'b1; din = 8'h3C; end
      if (i == 8) load_valid = 1'b0;
      if (i == 9) din = W'($urandom);
    end
    check("bp_bits", 32'(got16), 32'h5A3C);
    @(negedge clk);

    // Reset after bit 3 of F0, then 81
    din = 8'hF0; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mr_sout", 32'(sout), 32'd0);
    check("mr_valid", 32'(sout_valid), 32'd0);
    check("mr_frame_start", 32'(frame_start), 32'd0);
    check("mr_word_done", 32'(word_done), 32'd0);
    check("mr_ready", 32'(load_ready), 32'd1);
    din = 8'h81; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    got = '0;
    for (int i = 0; i < W; i++) begin
      if (i > 0) @(negedge clk);
      got = {got[W-2:0], sout};
      if (i == 0) check("mr81_frame_start", 32'(frame_start), 32'd1);
    end
    check("mr81_bits", 32'(got), 32'h81);

    // WIDTH=4 build
    din4 = 4'b1001; lv4 = 1'b1;
    @(negedge clk);
    lv4 = 1'b0; din4 = 4'b0110;
    got4 = '0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      got4 = {got4[2:0], sout4};
      check("w4_valid", 32'(sv4), 32'd1);
      check("w4_frame_start", 32'(fs4), 32'(i == 0));
      check("w4_word_done", 32'(wd4), 32'(i == 3));
    end
    check("w4_bits", 32'(got4), 32'b1001);
    @(negedge clk);
    check("w4_end_valid", 32'(sv4), 32'd0);
    check("w4_end_ready", 32'(ready4), 32'd1);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      din        = W'($urandom);
      load_valid = ($urandom_range(0, 9) < 6);
      reset      = ($urandom_range(0, 49) == 0);
    end
    @(negedge clk);
    reset = 1'b0; load_valid = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_piso_ctrl.md
SR_PISO_CTRL -- requirements
Module: sr_piso_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, word width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; every flop updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: din  input  WIDTH  parallel word to serialize, captured on load handshake.
REQ-005 Port: load_valid  input  1  upstream asserts when din holds a valid word.
REQ-006 Port: load_ready  output  1  block can accept a word this cycle.
REQ-007 Port: sout  output  1  serial bit stream; drives the d input of the 8-bit SIPO (SR_SIPO_eight).
REQ-008 Port: sout_valid  output  1  high in every cycle in which sout carries a word bit.
REQ-009 Port: frame_start  output  1  one-cycle pulse coincident with the first (MSB) bit of a word.
REQ-010 Port: word_done  output  1  one-cycle pulse coincident with the last (LSB) bit of a word.

Function
REQ-011 A word SHALL be accepted on a rising edge where load_valid and load_ready are both 1; din is captured into an internal shift register on that edge.
REQ-012 FSM SHALL have two states: IDLE (no word in flight) and SHIFT (word in flight).
REQ-013 IDLE -> SHIFT on acceptance; SHIFT -> IDLE when the last bit is driven and no new word is accepted; SHIFT -> SHIFT on acceptance during the last bit.
REQ-014 Bits SHALL be sent MSB first, so the first bit sent ends up in the SIPO's highest output bit and the SIPO's parallel output equals din after WIDTH bits.
REQ-015 The first bit SHALL appear on sout (with sout_valid=1 and frame_start=1) in the cycle immediately after the accepting edge; latency is 1 cycle.
REQ-016 A word SHALL occupy exactly WIDTH consecutive cycles of sout_valid=1, din[WIDTH-1] down to din[0].
REQ-017 A bit counter (0..WIDTH-1) SHALL track the bit position; word_done=1 when the counter equals WIDTH-1 in SHIFT.
REQ-018 load_ready SHALL be 1 in IDLE, and also in SHIFT when the counter equals WIDTH-1, giving gapless back-to-back words; otherwise 0.
REQ-019 load_ready SHALL be a combinational function of state and counter only, never of load_valid.
REQ-020 In the cycle after the last bit with no new word accepted: sout=0, sout_valid=0, frame_start=0, word_done=0.
REQ-021 In IDLE, sout SHALL be held at 0; din and load_valid SHALL have no effect on sout.
REQ-022 din changes while a word is in flight SHALL NOT alter the bits being sent.
REQ-023 sout, sout_valid, frame_start and word_done SHALL be registered outputs.

Reset
REQ-024 While reset=1 at a rising edge: state=IDLE, counter=0, shift register=0, sout=0, sout_valid=0, frame_start=0, word_done=0.
REQ-025 A handshake coinciding with reset=1 SHALL be ignored (word not accepted).
REQ-026 A reset during SHIFT SHALL abort the word; no further bits of it are emitted, and the next word starts cleanly from its MSB.
REQ-027 load_ready SHALL read 1 in the first cycle after reset deasserts.

Structure
REQ-028 Package sr_pkg SHALL hold the WIDTH default constant and the FSM state typedef (IDLE, SHIFT).
REQ-029 The parallel-load/shift-left register SHALL be a sub-module named piso_shreg (ports: clk, reset, load, shift, din, msb); sr_piso_ctrl holds the FSM, counter and handshake.

Verification
REQ-030 Single word: reset, then din=8'hA5 with one-cycle load_valid -> sout = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; frame_start on bit 1; word_done on bit 8; the downstream SIPO q = 8'hA5 after the 8th edge.
REQ-031 Back-to-back: load_valid held with 8'hFF then 8'h00 -> 16 consecutive sout_valid cycles, no gap; load_ready=1 only in IDLE and on bit 8.
REQ-032 Backpressure: load_valid=1 mid-word with din=8'h3C -> not accepted until the word_done cycle; din changes mid-word do not corrupt the current word.
REQ-033 Reset mid-word: send 8'hF0 and assert reset after bit 3 -> all outputs 0 on the next cycle; then 8'h81 is sent correctly MSB first.
REQ-034 Idle: no load_valid for 20 cycles after reset -> sout=0, sout_valid=0, load_ready=1 throughout.
REQ-035 WIDTH=4 build: din=4'b1001 -> 4 bits 1,0,0,1; word_done on the 4th bit.
